// File: rtl/scv_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: prefix bytes,
// the list of device status codes that never become key events, the
// key-event word layout and the frame receiver state encoding.
package scv_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

  // Number of bytes that follow E1 in the Pause make sequence.
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  // Status / acknowledge / error codes a keyboard may send.
  localparam int PS2_NUM_DISCARD = 8;
  localparam logic [PS2_NUM_DISCARD-1:0][7:0] PS2_DISCARD_CODES = {
    8'hAA, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hEE, 8'h00, 8'hFF
  };

  // Key event word, bit-for-bit identical to PS2_KEY.
  typedef struct packed {
    logic       toggle;
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } ps2_key_t;

  typedef enum logic [1:0] {
    FR_IDLE   = 2'd0,
    FR_DATA   = 2'd1,
    FR_PARITY = 2'd2,
    FR_STOP   = 2'd3
  } ps2_frame_state_e;

  // True when the byte is a status code rather than a scan code.
  function automatic logic ps2_is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < PS2_NUM_DISCARD; i++) begin
      if (b == PS2_DISCARD_CODES[i]) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Odd parity over data plus parity bit means the frame is intact.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes both lines, deglitches
// the clock, deframes 11-bit frames and abandons stalled partial frames.
module ps2_frame_rx
  import scv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int FILT_LEN       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       frame_abort_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

  logic [1:0]          clk_sync_q;
  logic [1:0]          dat_sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic                filt_q;
  logic                filt_d;
  logic                fall_s;

  ps2_frame_state_e    state_q, state_d;
  logic [7:0]          shift_q, shift_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic                par_q, par_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [7:0]          byte_q, byte_d;
  logic                vld_q, vld_d;
  logic                err_q, err_d;
  logic                abort_q, abort_d;

  // Two-flop synchronizers and clock sample history; lines idle high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      hist_q     <= '1;
      filt_q     <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      hist_q     <= {hist_q[FILT_LEN-2:0], clk_sync_q[1]};
      filt_q     <= filt_d;
    end
  end

  // Filtered clock follows only after FILT_LEN equal samples; flag falls.
  always_comb begin
    filt_d = filt_q;
    fall_s = 1'b0;
    if (filt_q && (hist_q == '0)) begin
      filt_d = 1'b0;
      fall_s = 1'b1;
    end else if (!filt_q && (hist_q == '1)) begin
      filt_d = 1'b1;
    end else begin
      filt_d = filt_q;
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= FR_IDLE;
      shift_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      byte_q   <= 8'h00;
      vld_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      byte_q   <= byte_d;
      vld_q    <= vld_d;
      err_q    <= err_d;
      abort_q  <= abort_d;
    end
  end

  // Next-state logic: bit capture on filtered falls, frame check, timeout.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    byte_d   = byte_q;
    vld_d    = 1'b0;
    err_d    = 1'b0;
    abort_d  = 1'b0;

    case (state_q)
      FR_IDLE: begin
        if (fall_s && !dat_sync_q[1]) begin
          state_d  = FR_DATA;
          bitcnt_d = 3'd0;
        end else begin
          state_d = FR_IDLE;
        end
      end
      FR_DATA: begin
        if (fall_s) begin
          shift_d  = {dat_sync_q[1], shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = FR_PARITY;
          end else begin
            state_d = FR_DATA;
          end
        end else begin
          state_d = FR_DATA;
        end
      end
      FR_PARITY: begin
        if (fall_s) begin
          par_d   = dat_sync_q[1];
          state_d = FR_STOP;
        end else begin
          state_d = FR_PARITY;
        end
      end
      FR_STOP: begin
        if (fall_s) begin
          state_d = FR_IDLE;
          if (dat_sync_q[1] && ps2_parity_ok(shift_q, par_q)) begin
            byte_d = shift_q;
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = FR_STOP;
        end
      end
      default: begin
        state_d = FR_IDLE;
      end
    endcase

    // A falling edge in the same cycle as expiry wins and reloads the count.
    if (state_q == FR_IDLE) begin
      tmo_d = '0;
    end else if (fall_s) begin
      tmo_d = '0;
    end else if (tmo_q >= TMO_LIMIT) begin
      tmo_d   = '0;
      state_d = FR_IDLE;
      abort_d = 1'b1;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  assign byte_o        = byte_q;
  assign byte_vld_o    = vld_q;
  assign frame_err_o   = err_q;
  assign frame_abort_o = abort_q;

endmodule

// File: rtl/ps2_keyrx.sv
// PS/2 keyboard receiver: turns deframed scan-code bytes into toggle-style
// key events, folding in the E0 (extended), F0 (break) and E1 (pause) prefixes.
module ps2_keyrx
  import scv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int FILT_LEN       = 4
) (
  input  logic        CLK_SYS,
  input  logic        RESET,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [10:0] PS2_KEY,
  output logic        ERR
);

  logic [7:0] byte_s;
  logic       byte_vld_s;
  logic       frame_err_s;
  logic       frame_abort_s;

  ps2_key_t   key_q, key_d;
  logic       err_q, err_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] skip_q, skip_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILT_LEN      (FILT_LEN)
  ) u_frame_rx (
    .clk_i        (CLK_SYS),
    .rst_i        (RESET),
    .ps2_clk_i    (PS2_CLK),
    .ps2_dat_i    (PS2_DAT),
    .byte_o       (byte_s),
    .byte_vld_o   (byte_vld_s),
    .frame_err_o  (frame_err_s),
    .frame_abort_o(frame_abort_s)
  );

  // Decoder state and the output event register.
  always_ff @(posedge CLK_SYS or posedge RESET) begin
    if (RESET) begin
      key_q  <= '0;
      err_q  <= 1'b0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= 3'd0;
    end else begin
      key_q  <= key_d;
      err_q  <= err_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
    end
  end

  // Byte decoder: prefixes set flags, Pause bytes are swallowed, status
  // codes are dropped, anything else emits one event and clears the flags.
  always_comb begin
    key_d  = key_q;
    err_d  = 1'b0;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;

    if (frame_err_s || frame_abort_s) begin
      err_d  = frame_err_s;
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = 3'd0;
    end else if (byte_vld_s) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_s == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_s == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else if (byte_s == PS2_PFX_PAUSE) begin
        skip_d = PS2_PAUSE_SKIP;
      end else if (ps2_is_discard(byte_s)) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        key_d.toggle  = ~key_q.toggle;
        key_d.pressed = ~brk_q;
        key_d.ext     = ext_q;
        key_d.code    = byte_s;
        ext_d         = 1'b0;
        brk_d         = 1'b0;
      end
    end else begin
      skip_d = skip_q;
    end
  end

  assign PS2_KEY = key_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_ps2_keyrx.sv
// Self-checking bench for ps2_keyrx: drives PS/2 frames with random
// half-periods and compares against a byte-level reference model.
module tb_ps2_keyrx;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic [10:0] key;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int ev_cnt = 0, err_cnt = 0, err_long = 0, bad_chg = 0;
  int last_chg = 0, last_err = 0;
  logic [10:0] prev_key = 11'd0;
  logic        prev_err = 1'b0;

  // reference model state
  logic [10:0] m_key = 11'd0;
  bit m_ext = 0, m_brk = 0;
  int m_skip = 0;

  ps2_keyrx #(.TIMEOUT_CYCLES(TMO), .FILT_LEN(4)) dut (
    .CLK_SYS(clk), .RESET(rst), .PS2_CLK(ps2c), .PS2_DAT(ps2d),
    .PS2_KEY(key), .ERR(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // event / error monitor sampled away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (key !== prev_key) begin
        ev_cnt   <= ev_cnt + 1;
        last_chg <= cyc;
        if (key[10] === prev_key[10]) bad_chg <= bad_chg + 1;
      end
      if (err === 1'b1) begin
        err_cnt  <= err_cnt + 1;
        last_err <= cyc;
        if (prev_err) err_long <= err_long + 1;
      end
    end
    prev_key <= key;
    prev_err <= err;
  end

  function automatic bit is_disc(input logic [7:0] b);
    return (b == 8'hAA || b == 8'hFA || b == 8'hFC || b == 8'hFD ||
            b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF);
  endfunction

  // Behavioural decoder: what one received frame should do.
  task automatic model_frame(input logic [7:0] b, input bit ok, output int mev, output int mer);
    mev = 0; mer = 0;
    if (!ok) begin
      mer = 1; m_ext = 0; m_brk = 0; m_skip = 0;
    end else if (m_skip > 0) begin
      m_skip = m_skip - 1;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (is_disc(b)) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      mev = 1; m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic model_clear();
    m_ext = 0; m_brk = 0; m_skip = 0;
  endtask

  // Drive the first nbits of a frame; t0 = cycle of the last clock fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits, output int t0);
    int h;
    h = $urandom_range(8, 14);
    t0 = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2d = bits[i];
      repeat (h) @(negedge clk);
      ps2c = 1'b0;
      if (i == nbits - 1) t0 = cyc;
      repeat (h) @(negedge clk);
      ps2c = 1'b1;
    end
    @(negedge clk); ps2d = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            output int ev, output int er, output int lat, output int elat);
    int e0, r0, t0;
    logic par;
    @(negedge clk);
    e0 = ev_cnt; r0 = err_cnt;
    par = (~^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11, t0);
    repeat (6) @(negedge clk);
    ev = ev_cnt - e0; er = err_cnt - r0;
    lat = last_chg - t0; elat = last_err - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (key !== 11'h000) begin miscompares++; $display("FAIL reset_key got=%h exp=000", key); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make_break();
    int ev, er, lat, elat, mev, mer;
    send_frame(8'h16, 0, 0, ev, er, lat, elat); model_frame(8'h16, 1, mev, mer);
    vectors++; if (key !== 11'h616 || key !== m_key) begin miscompares++; $display("FAIL make16_key got=%h exp=616", key); end
    vectors++; if (ev !== 1) begin miscompares++; $display("FAIL make16_events got=%0d exp=1", ev); end
    vectors++; if (lat < 6 || lat > 9) begin miscompares++; $display("FAIL make16_latency got=%0d exp=7..8", lat); end
    send_frame(8'hF0, 0, 0, ev, er, lat, elat); model_frame(8'hF0, 1, mev, mer);
    vectors++; if (ev !== 0) begin miscompares++; $display("FAIL f0_alone_events got=%0d exp=0", ev); end
    send_frame(8'h16, 0, 0, ev, er, lat, elat); model_frame(8'h16, 1, mev, mer);
    vectors++; if (key !== 11'h016 || ev !== 1) begin miscompares++; $display("FAIL break16 got=%h/%0d exp=016/1", key, ev); end
  endtask

  task automatic test_extended();
    int ev, er, lat, elat, mev, mer, tot;
    logic [7:0] seq [5] = '{8'hE0, 8'h5A, 8'hE0, 8'hF0, 8'h5A};
    tot = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], 0, 0, ev, er, lat, elat); model_frame(seq[i], 1, mev, mer);
      tot += ev;
      if (i == 1) begin
        vectors++; if (key !== 11'h75A) begin miscompares++; $display("FAIL ext_make got=%h exp=75A", key); end
      end
    end
    vectors++; if (key !== 11'h15A || key !== m_key) begin miscompares++; $display("FAIL ext_break got=%h exp=15A", key); end
    vectors++; if (tot !== 2) begin miscompares++; $display("FAIL ext_events got=%0d exp=2", tot); end
  endtask

  task automatic test_parity_error();
    int ev, er, lat, elat, mev, mer, el0;
    el0 = err_long;
    send_frame(8'h45, 1, 0, ev, er, lat, elat); model_frame(8'h45, 0, mev, mer);
    vectors++; if (ev !== 0 || er !== 1) begin miscompares++; $display("FAIL parity_err ev=%0d err=%0d exp ev=0 err=1", ev, er); end
    vectors++; if (err_long !== el0) begin miscompares++; $display("FAIL err_width got=%0d long pulses exp=0", err_long - el0); end
    vectors++; if (elat < 6 || elat > 9) begin miscompares++; $display("FAIL err_latency got=%0d exp=7..8", elat); end
    send_frame(8'hE0, 0, 0, ev, er, lat, elat); model_frame(8'hE0, 1, mev, mer);
    send_frame(8'h33, 0, 1, ev, er, lat, elat); model_frame(8'h33, 0, mev, mer);
    vectors++; if (er !== 1 || ev !== 0) begin miscompares++; $display("FAIL stop_err ev=%0d err=%0d exp ev=0 err=1", ev, er); end
    send_frame(8'h70, 0, 0, ev, er, lat, elat); model_frame(8'h70, 1, mev, mer);
    vectors++; if (key !== m_key || key[8:0] !== 9'h070) begin miscompares++; $display("FAIL err_clears_ext got=%h exp=%h", key, m_key); end
  endtask

  task automatic test_timeout();
    int ev, er, lat, elat, mev, mer, t0, r0;
    send_frame(8'hE0, 0, 0, ev, er, lat, elat); model_frame(8'hE0, 1, mev, mer);
    r0 = err_cnt;
    send_bits(11'b110_0101_0100, 5, t0);
    repeat (TMO + 10) @(negedge clk);
    model_clear();
    send_frame(8'h1E, 0, 0, ev, er, lat, elat); model_frame(8'h1E, 1, mev, mer);
    vectors++; if (key !== m_key || key[9:0] !== 10'h21E) begin miscompares++; $display("FAIL timeout_key got=%h exp=%h", key, m_key); end
    vectors++; if (err_cnt !== r0) begin miscompares++; $display("FAIL timeout_err got=%0d pulses exp=0", err_cnt - r0); end
  endtask

  task automatic test_pause();
    int ev, er, lat, elat, mev, mer, tot;
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      send_frame(seq[i], 0, 0, ev, er, lat, elat); model_frame(seq[i], 1, mev, mer);
      tot += ev;
    end
    vectors++; if (tot !== 0) begin miscompares++; $display("FAIL pause_events got=%0d exp=0", tot); end
    send_frame(8'h26, 0, 0, ev, er, lat, elat); model_frame(8'h26, 1, mev, mer);
    vectors++; if (key !== m_key || key[9:0] !== 10'h226) begin miscompares++; $display("FAIL after_pause got=%h exp=%h", key, m_key); end
  endtask

  task automatic test_random();
    int ev, er, lat, elat, mev, mer, r;
    logic [7:0] b;
    bit bad;
    logic [7:0] disc [8] = '{8'hAA, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 11);
      case (r)
        0, 1: b = 8'hE0;
        2, 3: b = 8'hF0;
        4: b = 8'hE1;
        5: b = disc[$urandom_range(0, 7)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      bad = ($urandom_range(0, 9) == 0);
      send_frame(b, bad, 0, ev, er, lat, elat); model_frame(b, !bad, mev, mer);
      vectors++;
      if (key !== m_key || ev !== mev || er !== mer) begin
        miscompares++;
        $display("FAIL random[%0d] byte=%h key=%h ev=%0d err=%0d exp key=%h ev=%0d err=%0d",
                 i, b, key, ev, er, m_key, mev, mer);
      end
    end
    vectors++; if (bad_chg !== 0) begin miscompares++; $display("FAIL key_change_without_toggle got=%0d exp=0", bad_chg); end
  endtask

  task automatic test_reset_midframe();
    int ev, er, lat, elat, mev, mer, t0;
    if (key === 11'h000) begin
      send_frame(8'h1C, 0, 0, ev, er, lat, elat); model_frame(8'h1C, 1, mev, mer);
    end
    send_bits(11'b111_0000_1010, 4, t0);
    @(negedge clk); rst = 1'b1;
    #1;
    vectors++; if (key !== 11'h000 || err !== 1'b0) begin miscompares++; $display("FAIL reset_mid key=%h err=%b exp 000/0", key, err); end
    repeat (3) @(negedge clk); rst = 1'b0;
    m_key = 11'd0; model_clear();
    repeat (3) @(negedge clk);
    send_frame(8'h29, 0, 0, ev, er, lat, elat); model_frame(8'h29, 1, mev, mer);
    vectors++; if (key !== 11'h629 || key !== m_key) begin miscompares++; $display("FAIL after_reset got=%h exp=629", key); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_parity_error();
    test_timeout();
    test_pause();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
